// File: rtl/fc_layer_engine_pkg.sv
// rtl/fc_layer_engine_pkg.sv - shared FSM encoding, default widths and lane slicing for the FC engine

// Lane `lane` of a packed bus holding `nlanes` lanes of width `w`; lane 0 sits in the MSBs.
`define FC_LANE_SLICE(bus, nlanes, lane, w) bus[((nlanes)-1-(lane))*(w) +: (w)]

package fc_layer_engine_pkg;

  localparam int DATA_WIDTH_DEF        = 8;
  localparam int WEIGHT_WIDTH_DEF      = 4;
  localparam int LANES_DEF             = 20;
  localparam int ACC_WIDTH_DEF         = 24;
  localparam int MAX_CHUNKS_DEF        = 64;
  localparam int MAX_OUT_DEF           = 512;
  localparam int ACT_ADDR_WIDTH_DEF    = 6;
  localparam int WEIGHT_ADDR_WIDTH_DEF = 15;
  localparam int OUT_ADDR_WIDTH_DEF    = 9;
  localparam int SHIFT_WIDTH           = 5;

  // Counter widths able to hold the full range 0..MAX inclusive
  localparam int CHUNK_CNT_WIDTH_DEF = $clog2(MAX_CHUNKS_DEF + 1);
  localparam int OUT_CNT_WIDTH_DEF   = $clog2(MAX_OUT_DEF + 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MAC   = 3'd1,
    ST_FLUSH = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } fc_state_e;

endpackage

// File: rtl/fc_layer_engine_if.sv
// rtl/fc_layer_engine_if.sv - sequencer, SRAM and output-port bundle of the FC engine

interface fc_layer_engine_if
  import fc_layer_engine_pkg::*;
#(
  parameter int DATA_WIDTH        = DATA_WIDTH_DEF,
  parameter int WEIGHT_WIDTH      = WEIGHT_WIDTH_DEF,
  parameter int LANES             = LANES_DEF,
  parameter int MAX_CHUNKS        = MAX_CHUNKS_DEF,
  parameter int MAX_OUT           = MAX_OUT_DEF,
  parameter int ACT_ADDR_WIDTH    = ACT_ADDR_WIDTH_DEF,
  parameter int WEIGHT_ADDR_WIDTH = WEIGHT_ADDR_WIDTH_DEF,
  parameter int OUT_ADDR_WIDTH    = OUT_ADDR_WIDTH_DEF
) ();

  localparam int CW = $clog2(MAX_CHUNKS + 1);
  localparam int NW = $clog2(MAX_OUT + 1);

  // Run control and configuration
  logic                          start;
  logic [CW-1:0]                 cfg_chunks;
  logic [NW-1:0]                 cfg_out_len;
  logic [SHIFT_WIDTH-1:0]        cfg_shift;
  logic                          cfg_relu;
  logic                          busy;
  logic                          done;

  // Activation and weight SRAM read ports
  logic [ACT_ADDR_WIDTH-1:0]     act_raddr;
  logic [LANES*DATA_WIDTH-1:0]   act_rdata;
  logic [WEIGHT_ADDR_WIDTH-1:0]  wgt_raddr;
  logic [LANES*WEIGHT_WIDTH-1:0] wgt_rdata;

  // Output write port
  logic                          out_we;
  logic [OUT_ADDR_WIDTH-1:0]     out_waddr;
  logic [DATA_WIDTH-1:0]         out_wdata;

  modport master (
    output start, cfg_chunks, cfg_out_len, cfg_shift, cfg_relu, act_rdata, wgt_rdata,
    input  busy, done, act_raddr, wgt_raddr, out_we, out_waddr, out_wdata
  );

  modport slave (
    input  start, cfg_chunks, cfg_out_len, cfg_shift, cfg_relu, act_rdata, wgt_rdata,
    output busy, done, act_raddr, wgt_raddr, out_we, out_waddr, out_wdata
  );

endinterface

// File: rtl/fc_lane_mac.sv
// rtl/fc_lane_mac.sv - combinational signed LANES-way dot product of one activation/weight chunk

module fc_lane_mac #(
  parameter int LANES        = 20,
  parameter int DATA_WIDTH   = 8,
  parameter int WEIGHT_WIDTH = 4,
  parameter int ACC_WIDTH    = 24
) (
  input  logic [LANES*DATA_WIDTH-1:0]   act_i,
  input  logic [LANES*WEIGHT_WIDTH-1:0] wgt_i,
  output logic signed [ACC_WIDTH-1:0]   sum_o
);

  localparam int PW = DATA_WIDTH + WEIGHT_WIDTH;

  // Unpack lanes MSB-first, multiply signed, sign-extend and sum
  always_comb begin
    logic signed [DATA_WIDTH-1:0]   a;
    logic signed [WEIGHT_WIDTH-1:0] w;
    logic signed [PW-1:0]           p;
    a     = '0;
    w     = '0;
    p     = '0;
    sum_o = '0;
    for (int l = 0; l < LANES; l++) begin
      a     = $signed(`FC_LANE_SLICE(act_i, LANES, l, DATA_WIDTH));
      w     = $signed(`FC_LANE_SLICE(wgt_i, LANES, l, WEIGHT_WIDTH));
      p     = PW'(a) * PW'(w);
      sum_o = sum_o + ACC_WIDTH'(p);
    end
  end

endmodule

// File: rtl/fc_layer_engine.sv
// rtl/fc_layer_engine.sv - runtime-configured fully-connected layer engine (FSM, accumulator, quantizer)

module fc_layer_engine
  import fc_layer_engine_pkg::*;
#(
  parameter int DATA_WIDTH        = DATA_WIDTH_DEF,
  parameter int WEIGHT_WIDTH      = WEIGHT_WIDTH_DEF,
  parameter int LANES             = LANES_DEF,
  parameter int ACC_WIDTH         = ACC_WIDTH_DEF,
  parameter int MAX_CHUNKS        = MAX_CHUNKS_DEF,
  parameter int MAX_OUT           = MAX_OUT_DEF,
  parameter int ACT_ADDR_WIDTH    = ACT_ADDR_WIDTH_DEF,
  parameter int WEIGHT_ADDR_WIDTH = WEIGHT_ADDR_WIDTH_DEF,
  parameter int OUT_ADDR_WIDTH    = OUT_ADDR_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             srstn,
  fc_layer_engine_if.slave bus
);

  localparam int CW = $clog2(MAX_CHUNKS + 1);
  localparam int NW = $clog2(MAX_OUT + 1);
  // Headroom so the rounding bias cannot wrap for any shift up to 31
  localparam int QW = ACC_WIDTH + 33;
  localparam logic signed [QW-1:0] Q_MAX = (QW'(1) <<< (DATA_WIDTH - 1)) - QW'(1);
  localparam logic signed [QW-1:0] Q_MIN = -Q_MAX - QW'(1);

  fc_state_e                     state_q;
  logic [CW-1:0]                 cfg_chunks_q;
  logic [NW-1:0]                 cfg_out_len_q;
  logic [SHIFT_WIDTH-1:0]        cfg_shift_q;
  logic                          cfg_relu_q;
  logic [CW-1:0]                 k_q;
  logic [NW-1:0]                 n_q;
  logic [WEIGHT_ADDR_WIDTH-1:0]  wp_q;
  logic [ACT_ADDR_WIDTH-1:0]     act_raddr_q;
  logic [WEIGHT_ADDR_WIDTH-1:0]  wgt_raddr_q;
  logic                          busy_q;
  logic                          done_q;
  logic                          out_we_q;
  logic [OUT_ADDR_WIDTH-1:0]     out_waddr_q;
  logic [DATA_WIDTH-1:0]         out_wdata_q;
  logic                          rd_vld_q;
  logic                          rd_first_q;
  logic signed [ACC_WIDTH-1:0]   acc_q;
  logic signed [ACC_WIDTH-1:0]   acc_d;
  logic signed [ACC_WIDTH-1:0]   lane_sum;

  // Round, shift, saturate and optionally rectify one accumulator value
  function automatic logic [DATA_WIDTH-1:0] quantize(
    input logic signed [ACC_WIDTH-1:0] x,
    input logic [SHIFT_WIDTH-1:0]      s,
    input logic                        relu
  );
    logic signed [QW-1:0]   v;
    logic [DATA_WIDTH-1:0]  r;
    v = QW'(x);
    if (s != '0) v = v + (QW'(1) <<< (s - 1'b1));
    v = v >>> s;
    if (v > Q_MAX)      r = Q_MAX[DATA_WIDTH-1:0];
    else if (v < Q_MIN) r = Q_MIN[DATA_WIDTH-1:0];
    else                r = v[DATA_WIDTH-1:0];
    if (relu && r[DATA_WIDTH-1]) r = '0;
    return r;
  endfunction

  fc_lane_mac #(
    .LANES       (LANES),
    .DATA_WIDTH  (DATA_WIDTH),
    .WEIGHT_WIDTH(WEIGHT_WIDTH),
    .ACC_WIDTH   (ACC_WIDTH)
  ) u_lane_mac (
    .act_i(bus.act_rdata),
    .wgt_i(bus.wgt_rdata),
    .sum_o(lane_sum)
  );

  // SRAM data arrives one cycle after its address; chunk 0 reloads, later chunks add (wrapping)
  always_comb begin
    acc_d = acc_q;
    if (rd_vld_q) acc_d = rd_first_q ? lane_sum : acc_q + lane_sum;
  end

  // Accumulator register
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  // Run FSM with counters and registered outputs; addresses are issued one cycle ahead of MAC use
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      state_q       <= ST_IDLE;
      cfg_chunks_q  <= '0;
      cfg_out_len_q <= '0;
      cfg_shift_q   <= '0;
      cfg_relu_q    <= 1'b0;
      k_q           <= '0;
      n_q           <= '0;
      wp_q          <= '0;
      act_raddr_q   <= '0;
      wgt_raddr_q   <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      out_we_q      <= 1'b0;
      out_waddr_q   <= '0;
      out_wdata_q   <= '0;
      rd_vld_q      <= 1'b0;
      rd_first_q    <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      out_we_q   <= 1'b0;
      rd_vld_q   <= 1'b0;
      rd_first_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            cfg_chunks_q  <= bus.cfg_chunks;
            cfg_out_len_q <= bus.cfg_out_len;
            cfg_shift_q   <= bus.cfg_shift;
            cfg_relu_q    <= bus.cfg_relu;
            k_q           <= '0;
            n_q           <= '0;
            wp_q          <= '0;
            busy_q        <= 1'b1;
            if (bus.cfg_chunks == '0 || bus.cfg_out_len == '0) begin
              // Empty run: no reads, no writes, straight to the done pulse
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q     <= ST_MAC;
              act_raddr_q <= '0;
              wgt_raddr_q <= '0;
              wp_q        <= WEIGHT_ADDR_WIDTH'(1);
            end
          end
        end
        ST_MAC: begin
          rd_vld_q   <= 1'b1;
          rd_first_q <= (k_q == '0);
          if (k_q == cfg_chunks_q - 1'b1) begin
            state_q <= ST_FLUSH;
          end else begin
            k_q         <= k_q + 1'b1;
            act_raddr_q <= ACT_ADDR_WIDTH'(k_q + 1'b1);
            wgt_raddr_q <= wp_q;
            wp_q        <= wp_q + 1'b1;
          end
        end
        ST_FLUSH: begin
          // Last chunk lands this cycle, so quantize the value about to enter acc
          state_q     <= ST_WRITE;
          out_we_q    <= 1'b1;
          out_waddr_q <= OUT_ADDR_WIDTH'(n_q);
          out_wdata_q <= quantize(acc_d, cfg_shift_q, cfg_relu_q);
        end
        ST_WRITE: begin
          if (n_q == cfg_out_len_q - 1'b1) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q     <= ST_MAC;
            n_q         <= n_q + 1'b1;
            k_q         <= '0;
            act_raddr_q <= '0;
            wgt_raddr_q <= wp_q;
            wp_q        <= wp_q + 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.act_raddr = act_raddr_q;
  assign bus.wgt_raddr = wgt_raddr_q;
  assign bus.out_we    = out_we_q;
  assign bus.out_waddr = out_waddr_q;
  assign bus.out_wdata = out_wdata_q;

endmodule

// File: tb/tb_fc_layer_engine.sv
// tb/tb_fc_layer_engine.sv - self-checking bench for fc_layer_engine

module tb_fc_layer_engine;
  import fc_layer_engine_pkg::*;

  localparam int LANES = 20;
  localparam int DW    = 8;
  localparam int WW    = 4;

  typedef struct {
    int c; int n; int s; bit relu;
    int a0; int arest; int w0; int wrest;
    int exp; bit poke;
  } vec_t;

  typedef struct { int addr; int data; int cyc; } wr_t;

  logic clk = 1'b0;
  logic srstn = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   wr_count = 0;
  wr_t  sb[$];
  vec_t vt[10];

  logic [LANES*DW-1:0] act_mem [64];
  logic [LANES*WW-1:0] wgt_mem [512];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fc_layer_engine_if bus ();
  fc_layer_engine dut (.clk(clk), .srstn(srstn), .bus(bus));

  // Single-cycle-latency SRAM models
  always @(posedge clk) begin
    bus.act_rdata <= act_mem[bus.act_raddr];
    bus.wgt_rdata <= wgt_mem[bus.wgt_raddr[8:0]];
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Scoreboard: every write strobe pops and compares one expected record
  always @(negedge clk) begin
    wr_t e;
    if (bus.out_we === 1'b1) begin
      wr_count++;
      if (sb.size() == 0) begin
        flag("unexpected_write");
      end else begin
        e = sb.pop_front();
        chk("wr_addr", bus.out_waddr, e.addr);
        chk("wr_data", $signed(bus.out_wdata), e.data);
        chk("wr_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic load(input int a0, input int arest, input int w0, input int wrest);
    for (int i = 0; i < 64; i++)
      for (int l = 0; l < LANES; l++)
        act_mem[i][(LANES-1-l)*DW +: DW] = DW'((l == 0) ? a0 : arest);
    for (int i = 0; i < 512; i++)
      for (int l = 0; l < LANES; l++)
        wgt_mem[i][(LANES-1-l)*WW +: WW] = WW'((l == 0) ? w0 : wrest);
  endtask

  task automatic run(input vec_t v);
    int t, exp_done, rel, nn, kk, wc0;
    bit seen;
    load(v.a0, v.arest, v.w0, v.wrest);
    @(negedge clk);
    bus.cfg_chunks  = 7'(v.c);
    bus.cfg_out_len = 10'(v.n);
    bus.cfg_shift   = 5'(v.s);
    bus.cfg_relu    = v.relu;
    bus.start       = 1'b1;
    t   = cyc;
    wc0 = wr_count;
    if (v.c > 0)
      for (int i = 0; i < v.n; i++) sb.push_back('{i, v.exp, t + (i + 1) * (v.c + 2)});
    exp_done = (v.c == 0 || v.n == 0) ? t + 1 : t + v.n * (v.c + 2) + 1;
    @(negedge clk);
    seen = 1'b0;
    while (!seen && cyc < exp_done + 10) begin
      bus.start = 1'b0;
      if (v.poke && cyc == t + 3) begin
        // Ignored: engine is mid-run; config changes must not leak in either
        bus.start       = 1'b1;
        bus.cfg_chunks  = 7'd1;
        bus.cfg_out_len = 10'd1;
        bus.cfg_shift   = 5'd0;
      end
      if (cyc <= exp_done) chk("busy_in_run", bus.busy, 1);
      if (v.c > 0) begin
        rel = cyc - t - 1;
        nn  = rel / (v.c + 2);
        kk  = rel % (v.c + 2);
        if (nn < v.n && kk < v.c) begin
          chk("act_raddr", bus.act_raddr, kk);
          chk("wgt_raddr", bus.wgt_raddr, nn * v.c + kk);
        end
      end
      if (bus.done === 1'b1) begin
        chk("done_cycle", cyc, exp_done);
        seen = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    bus.start = 1'b0;
    if (!seen) flag("done_timeout");
    @(negedge clk);
    chk("busy_after_done", bus.busy, 0);
    chk("done_one_cycle", bus.done, 0);
    chk("pending_writes", sb.size(), 0);
    chk("write_count", wr_count - wc0, (v.c == 0) ? 0 : v.n);
    sb.delete();
  endtask

  initial begin
    int t;
    bus.start = 1'b0; bus.cfg_chunks = '0; bus.cfg_out_len = '0;
    bus.cfg_shift = '0; bus.cfg_relu = 1'b0;
    bus.act_rdata = '0; bus.wgt_rdata = '0;

    //        c  n  s relu  a0 arest  w0 wrest  exp poke
    vt[0] = '{1, 1, 0, 0,    1,   1,   1,   1,   20, 0};
    vt[1] = '{2, 3, 2, 0,    3,   3,  -1,  -1,  -30, 1};
    vt[2] = '{4, 1, 0, 0,  127, 127,   7,   7,  127, 0};
    vt[3] = '{4, 1, 0, 0,  127, 127,  -8,  -8, -128, 0};
    vt[4] = '{4, 1, 0, 1,  127, 127,  -8,  -8,    0, 0};
    vt[5] = '{1, 1, 3, 0,    3,   0,   4,  -4,    2, 0};
    vt[6] = '{1, 1, 3, 0,   -3,   0,   4,  -4,   -1, 0};
    vt[7] = '{3, 2, 4, 1,    5,   5,   3,   3,   56, 0};
    vt[8] = '{0, 3, 0, 0,    1,   1,   1,   1,    0, 1};
    vt[9] = '{2, 0, 0, 0,    1,   1,   1,   1,    0, 0};

    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_out_we", bus.out_we, 0);
    chk("rst_act_raddr", bus.act_raddr, 0);
    chk("rst_wgt_raddr", bus.wgt_raddr, 0);
    chk("rst_out_wdata", bus.out_wdata, 0);
    srstn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) run(vt[i]);

    // Reset during MAC of neuron 1 of a 3-neuron run
    load(3, 3, -1, -1);
    @(negedge clk);
    bus.cfg_chunks = 7'd2; bus.cfg_out_len = 10'd3; bus.cfg_shift = 5'd2; bus.cfg_relu = 1'b0;
    bus.start = 1'b1;
    t = cyc;
    sb.push_back('{0, -30, t + 4});
    @(negedge clk);
    bus.start = 1'b0;
    while (cyc < t + 5) @(negedge clk);
    chk("pre_rst_wgt_raddr", bus.wgt_raddr, 2);
    #1 srstn = 1'b0;
    #1;
    chk("arst_busy", bus.busy, 0);
    chk("arst_done", bus.done, 0);
    chk("arst_out_we", bus.out_we, 0);
    chk("arst_act_raddr", bus.act_raddr, 0);
    chk("arst_wgt_raddr", bus.wgt_raddr, 0);
    chk("arst_out_waddr", bus.out_waddr, 0);
    chk("arst_out_wdata", bus.out_wdata, 0);
    chk("arst_first_write_seen", sb.size(), 0);
    repeat (8) begin
      @(negedge clk);
      chk("arst_no_done", bus.done, 0);
    end
    srstn = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_idle_done", bus.done, 0);
      chk("post_rst_idle_busy", bus.busy, 0);
    end
    run(vt[1]);
    run(vt[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fc_layer_engine.md
# fc_layer_engine

Parametrised fully-connected layer engine, the next-generation FC datapath for the LeNet accelerator. One instance runs any FC layer, so FC1 and FC2 are two runs with different runtime configuration. Each run streams LANES activations and LANES weights per cycle from single-cycle-latency SRAMs, accumulates signed products, and applies rounding shift, saturation and optional ReLU. It writes one quantized byte per output neuron, and a start/busy/done handshake links it to the layer sequencer.

## Interface
- DATA_WIDTH, 8, signed activation width (input and output)
- WEIGHT_WIDTH, 4, signed weight width
- LANES, 20, activations/weights consumed per cycle
- ACC_WIDTH, 24, signed accumulator width
- MAX_CHUNKS, 64, max input chunks (LANES activations each) per neuron
- MAX_OUT, 512, max output neurons
- ACT_ADDR_WIDTH, 6; WEIGHT_ADDR_WIDTH, 15; OUT_ADDR_WIDTH, 9

Ports:
- clk  in  1  clock; single clock domain
- srstn  in  1  reset; asynchronous, active-low
- start  in  1  one-cycle run request; sampled only while idle
- cfg_chunks  in  clog2(MAX_CHUNKS+1)  chunks per neuron (C); latched on accepted start
- cfg_out_len  in  clog2(MAX_OUT+1)  neuron count (N); latched
- cfg_shift  in  5  quantize right-shift (S); latched
- cfg_relu  in  1  1 = clamp negatives to 0; latched
- busy  out  1  high from cycle after accepted start until done
- done  out  1  one-cycle pulse at run end
- act_raddr  out  ACT_ADDR_WIDTH  activation SRAM address
- act_rdata  in  LANES*DATA_WIDTH  lane 0 in MSBs
- wgt_raddr  out  WEIGHT_ADDR_WIDTH  weight SRAM address
- wgt_rdata  in  LANES*WEIGHT_WIDTH  lane 0 in MSBs
- out_we  out  1  output write strobe
- out_waddr  out  OUT_ADDR_WIDTH  neuron index
- out_wdata  out  DATA_WIDTH  quantized result

## Operation
- FSM: IDLE -> MAC -> FLUSH -> WRITE -> (MAC for next neuron | DONE) -> IDLE.
- IDLE: start=1 latches config, clears neuron index n and weight pointer wp to 0, and goes to MAC.
- start=1 with C=0 or N=0: go directly to DONE; no reads, no writes.
- MAC, chunk k = 0..C-1, one cycle each:
  - act_raddr = k; wgt_raddr = wp; wp increments every cycle.
  - Weights are stored neuron-major and contiguous, so neuron n chunk k is at n*C+k.
- Accumulation, one cycle after each address:
  - Sum the LANES signed products (DATA_WIDTH x WEIGHT_WIDTH).
  - Chunk 0 loads acc; later chunks add to acc.
  - Arithmetic is sign-extended to ACC_WIDTH; overflow wraps (no saturation inside acc).
- FLUSH: the last chunk's data arrives and is accumulated.
- WRITE: out_we=1, out_waddr=n, out_wdata = Q(acc). Then n increments. Go to DONE if n==N-1, else MAC.
- Q(x), in order:
  - Rounding: if S>0, x += 1<<(S-1).
  - Arithmetic >>S.
  - Saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - If cfg_relu, negatives become 0.
- DONE: done=1 for one cycle, then IDLE.
- start while not IDLE is ignored; config changes mid-run have no effect.
- Outputs when not in MAC or WRITE:
  - Read addresses hold their last value.
  - out_we=0; out_waddr and out_wdata hold their last value.

## Timing
- Reset values: busy=0, done=0, out_we=0, all addresses 0, out_wdata=0, FSM in IDLE, acc=0.
- Reset asserted mid-run aborts immediately: no further writes, no done pulse.
- Latency:
  - Start accepted at cycle t: first reads at t+1.
  - Each neuron takes C+2 cycles.
  - The write for neuron n occurs at t+(n+1)(C+2).
  - done is at t+N(C+2)+1.
  - Run total: N(C+2)+1 cycles from start to done.
- SRAM read latency is exactly 1 cycle; rdata is sampled in the cycle following its address.
- busy is high in MAC, FLUSH, WRITE and DONE; low in IDLE. A new start is accepted the cycle after done.

## Structure
- Shared package/header holds:
  - the FSM state encoding;
  - the lane-packing slice macros;
  - clog2-derived widths.
- Sub-module fc_lane_mac computes the combinational signed LANES-way product sum, unpacked MSB-first, sign-extended to ACC_WIDTH.
- The top-level engine holds:
  - FSM and counters;
  - the acc register;
  - the quantizer and the write port.

## Test plan
- C=1, N=1, S=0, relu=0:
  - Stimulus: all activations 1, all weights 1.
  - Expect: write 20 at addr 0 at t+3; done at t+4.
- C=2, N=3, S=2, relu=0:
  - Stimulus: activations 3, weights -1.
  - Expect: acc=-120, Q=-30, three writes at t+4, t+8, t+12.
  - Expect: wgt_raddr sequence 0..5; done at t+13.
- Saturation and ReLU, C=4, S=0, activations 127, weights 7 (acc=71120):
  - Expect: out 127.
  - With weights -8 and relu=0: out -128.
  - With weights -8 and relu=1: out 0.
- Rounding, S=3:
  - Stimulus: acc=12 (one lane 3x4, rest 0).
  - Expect: (12+4)>>3 = 2; acc=-12 gives -1.
- C=0 start:
  - Expect: done at t+1, out_we never high.
  - Expect: start pulses during a run are ignored, with an unchanged write count.
- Reset asserted mid-MAC of neuron 1 of N=3:
  - Expect: outputs return to reset values asynchronously; no further writes; no done pulse.
  - Expect: a fresh run after reset completes normally.
